cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, execute-phase length in cycles, legal range 1..4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port run, input, 1, permits fetch of a new instruction.
REQ-005 SHALL have port instrCode, input, 32, instruction-memory read data, valid only when imemReady=1.
REQ-006 SHALL have port imemReady, input, 1, instruction-memory data-valid response.
REQ-007 SHALL have port imemReq, output, 1, instruction fetch request.
REQ-008 SHALL have port irLoad, output, 1, datapath instruction-register load strobe.
REQ-009 SHALL have port pcEn, output, 1, PC advance strobe.
REQ-010 SHALL have port regFileWe, output, 1, register-file write enable.
REQ-011 SHALL have port aluSrcB, output, 1, ALU B-operand select: 0=rs2, 1=immediate.
REQ-012 SHALL have port aluOP, output, 4, ALU operation code.
REQ-013 SHALL have port instrDone, output, 1, retire pulse.
REQ-014 SHALL have port illegalInstr, output, 1, sticky trap flag.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB, TRAP.
REQ-016 IDLE: all strobes 0; go to FETCH when run=1, else stay in IDLE.
REQ-017 FETCH: imemReq=1 and hold; on imemReady=1, capture instrCode into the internal IR, pulse irLoad the same cycle, go to DECODE; run is ignored while in FETCH.
REQ-018 DECODE: one cycle; latch decoded aluOP and aluSrcB; legal -> EXEC, illegal -> TRAP.
REQ-019 EXEC: exactly EXEC_CYCLES cycles using a down-counter; aluOP and aluSrcB held at the latched values.
REQ-020 WB: one cycle; regFileWe=1, pcEn=1, instrDone=1; next state FETCH if run=1, else IDLE.
REQ-021 TRAP: illegalInstr=1, all other strobes 0, no exit except reset.
REQ-022 Latency with zero-wait memory SHALL be EXEC_CYCLES+3 cycles from FETCH entry to the WB cycle inclusive.
REQ-023 aluOP encoding SHALL be: ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, SLT 0101, SLTU 0110, XOR 0111, OR 1000, AND 1001.
REQ-024 aluOP SHALL be 0000 and aluSrcB 0 outside EXEC and WB, never X.
REQ-025 R-type (opcode 0110011): select on {instr[30], funct3}; funct7 must be 0000000, or 0100000 with funct3 000/101 only; anything else is illegal.
REQ-026 Any opcode not enabled SHALL be illegal.

Reset
REQ-027 Reset SHALL force IDLE, clear IR, latched aluOP/aluSrcB, exec counter and illegalInstr, and drive all outputs 0 from the first post-reset edge.
REQ-028 Reset mid-FETCH, EXEC or WB SHALL abort the instruction with no write or PC strobe on or after the reset edge.

Configuration
REQ-029 Macro CPU_SEQ_ITYPE_EN defined: opcode 0010011 is legal with aluSrcB=1; funct3 000 -> ADD regardless of instr[30]; SLLI requires funct7=0000000; SRLI/SRAI require funct7 0000000/0100000; other I-type funct3 values map as in R-type.
REQ-030 Macro CPU_SEQ_ITYPE_EN undefined: opcode 0010011 is illegal and aluSrcB is tied to 0.

Structure
REQ-031 Package cpu_seq_pkg SHALL hold the state enum, the aluOP localparams and the opcode localparams.
REQ-032 Combinational sub-module alu_op_decoder SHALL map IR to {aluOP, aluSrcB, legal}; the FSM resides in cpu_sequencer.

Verification
REQ-033 run=1, imemReady=1, instr 0x40B50533 (sub), EXEC_CYCLES=1 -> irLoad cycle 0, aluOP=0001 cycles 2-3, regFileWe/pcEn/instrDone cycle 3.
REQ-034 imemReady held low 5 cycles -> imemReq high throughout, irLoad only on the ready cycle, no other strobes.
REQ-035 instr 0x02B50533 (funct7 0000001) -> illegalInstr=1 from the cycle after DECODE, sticky; reset clears it.
REQ-036 EXEC_CYCLES=4, instr 0x00B57533 (and) -> aluOP=1001 for 5 cycles, single WB pulse, total 7 cycles.
REQ-037 reset asserted in the second EXEC cycle -> no regFileWe/pcEn, state IDLE, all outputs 0 the next cycle.
REQ-038 instr 0x00A50513 (addi) -> with CPU_SEQ_ITYPE_EN: aluOP=0000, aluSrcB=1, writeback; without it: TRAP.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU control sequencer.
// Optional I-type support is enabled by defining CPU_SEQ_ITYPE_EN.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } seq_state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Map {instr[30], funct3} onto the ALU operation code.
  function automatic logic [3:0] alu_map(input logic alt, input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction decoder: IR -> {aluOP, aluSrcB, legal}.
// Defining CPU_SEQ_ITYPE_EN adds the register-immediate ALU opcode.
module alu_op_decoder
  import cpu_seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  aluOP,
  output logic        aluSrcB,
  output logic        legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = ir[6:0];
  assign funct7        = ir[31:25];
  assign funct3        = ir[14:12];
  assign unused_fields = ^{ir[24:15], ir[11:7]};

  // Decode opcode/funct fields into ALU controls and legality.
  always_comb begin
    aluOP   = ALU_ADD;
    aluSrcB = 1'b0;
    legal   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        aluOP = alu_map(ir[30], funct3);
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
`ifdef CPU_SEQ_ITYPE_EN
      OPC_ITYPE: begin
        aluSrcB = 1'b1;
        case (funct3)
          3'b000: begin
            aluOP = ALU_ADD;
            legal = 1'b1;
          end
          3'b001: begin
            aluOP = ALU_SLL;
            legal = (funct7 == F7_BASE);
          end
          3'b101: begin
            aluOP = alu_map(ir[30], funct3);
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: begin
            aluOP = alu_map(1'b0, funct3);
            legal = 1'b1;
          end
        endcase
      end
`endif
      default: begin
        aluOP   = ALU_ADD;
        aluSrcB = 1'b0;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: IDLE/FETCH/DECODE/EXEC/WB with sticky TRAP.
// Defining CPU_SEQ_ITYPE_EN enables register-immediate ALU instructions.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instrCode,
  input  logic        imemReady,
  output logic        imemReq,
  output logic        irLoad,
  output logic        pcEn,
  output logic        regFileWe,
  output logic        aluSrcB,
  output logic [3:0]  aluOP,
  output logic        instrDone,
  output logic        illegalInstr
);

  localparam logic [1:0] EXEC_LOAD = 2'(EXEC_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  op_q, op_d;
  logic        srcb_q, srcb_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ill_q, ill_d;

  logic [3:0]  dec_op;
  logic        dec_srcb;
  logic        dec_legal;

  alu_op_decoder u_dec (
    .ir      (ir_q),
    .aluOP   (dec_op),
    .aluSrcB (dec_srcb),
    .legal   (dec_legal)
  );

  // State and datapath-control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      op_q    <= '0;
      srcb_q  <= 1'b0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      srcb_q  <= srcb_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state and strobe generation; ALU controls only leave zero in EXEC/WB.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    op_d         = op_q;
    srcb_d       = srcb_q;
    cnt_d        = cnt_q;
    ill_d        = ill_q;
    imemReq      = 1'b0;
    irLoad       = 1'b0;
    pcEn         = 1'b0;
    regFileWe    = 1'b0;
    instrDone    = 1'b0;
    aluOP        = '0;
    aluSrcB      = 1'b0;
    illegalInstr = ill_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          irLoad  = 1'b1;
          ir_d    = instrCode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        op_d   = dec_op;
        srcb_d = dec_srcb;
        cnt_d  = EXEC_LOAD;
        if (dec_legal) begin
          state_d = EXEC;
        end else begin
          ill_d   = 1'b1;
          state_d = TRAP;
        end
      end
      EXEC: begin
        aluOP   = op_q;
        aluSrcB = srcb_q;
        if (cnt_q == '0) state_d = WB;
        else             cnt_d   = cnt_q - 2'd1;
      end
      WB: begin
        aluOP     = op_q;
        aluSrcB   = srcb_q;
        regFileWe = 1'b1;
        pcEn      = 1'b1;
        instrDone = 1'b1;
        state_d   = run ? FETCH : IDLE;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
